// File: rtl/gpio_bus_ctrl_if.sv
// Request/response bus between a processor data port and gpio_bus_ctrl.
// A transfer on either channel happens on a rising edge where valid and ready are both high.
interface gpio_bus_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_hit;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_rdata
  );
endinterface

// File: rtl/gpio_bus_ctrl.sv
// Memory-mapped GPIO controller: one load/store in flight, response for every request.
// Optional interrupt-pending register enabled by defining GPIO_IRQ_EN.
module gpio_bus_ctrl #(
  parameter logic [31:0] GPIO_OUT_ADDR = 32'h0000ABCD,
  parameter logic [31:0] GPIO_IN_ADDR  = 32'h0000ABD0,
  parameter logic [31:0] GPIO_IRQ_ADDR = 32'h0000ABD4
) (
  input  logic              clk,
  input  logic              rst_n,
  gpio_bus_ctrl_if.slave    bus,
  output logic [31:0]       gpio_out,
  input  logic [31:0]       gpio_in,
  output logic              irq,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    WRITE  = 3'd2,
    READ   = 3'd3,
    RESP   = 3'd4
  } state_t;

`ifdef GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  state_t      state, state_nxt;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic        eq_out, eq_in, eq_irq;
  logic        sel_out, sel_in, sel_irq;
  logic [31:0] sync1, gpio_in_sync, irq_pending;
  logic [31:0] read_data;
  logic        resp_hit_q;
  logic [31:0] resp_rdata_q;

  assign eq_out = (addr_q == GPIO_OUT_ADDR);
  assign eq_in  = (addr_q == GPIO_IN_ADDR);
  assign eq_irq = IRQ_EN && (addr_q == GPIO_IRQ_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bus.req_valid) state_nxt = DECODE;
      DECODE: begin
        if (we_q && eq_out)                          state_nxt = WRITE;
        else if (!we_q && (eq_out || eq_in || eq_irq)) state_nxt = READ;
        else                                         state_nxt = RESP;
      end
      WRITE:  state_nxt = RESP;
      READ:   state_nxt = RESP;
      RESP:   if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign state_dbg      = state;

  always_comb begin
    read_data = '0;
    if (sel_out)      read_data = gpio_out;
    else if (sel_in)  read_data = gpio_in_sync;
    else if (sel_irq) read_data = irq_pending;
  end

  // gpio_out is written on the edge entering WRITE so the pins move a cycle before the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_out      <= 1'b0;
      sel_in       <= 1'b0;
      sel_irq      <= 1'b0;
      gpio_out     <= '0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == DECODE) begin
        sel_out <= eq_out;
        sel_in  <= eq_in;
        sel_irq <= eq_irq;
        if (state_nxt == WRITE) gpio_out <= wdata_q;
        if (state_nxt == RESP) begin
          resp_hit_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
      end
      if (state == WRITE) begin
        resp_hit_q   <= 1'b1;
        resp_rdata_q <= '0;
      end
      if (state == READ) begin
        resp_hit_q   <= 1'b1;
        resp_rdata_q <= read_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1        <= '0;
      gpio_in_sync <= '0;
    end else begin
      sync1        <= gpio_in;
      gpio_in_sync <= sync1;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [31:0] sync_prev;
  logic        irq_q;
  logic        irq_clr;

  // A rising edge landing on the clearing READ edge survives the clear.
  assign irq_clr = (state == READ) && sel_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_prev   <= '0;
      irq_pending <= '0;
      irq_q       <= 1'b0;
    end else begin
      sync_prev   <= gpio_in_sync;
      irq_pending <= (irq_pending & ~{32{irq_clr}}) | (gpio_in_sync & ~sync_prev);
      irq_q       <= |irq_pending;
    end
  end

  assign irq = irq_q;
`else
  assign irq_pending = '0;
  assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_bus_ctrl.sv
// Directed self-checking bench for gpio_bus_ctrl; define GPIO_IRQ_EN to cover the interrupt build.
module tb_gpio_bus_ctrl;
  logic        clk;
  logic        rst_n;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in;
  logic        irq;
  logic [2:0]  state_dbg;
  int          n_tests;
  int          n_fail;
  logic [31:0] out_c2;

  gpio_bus_ctrl_if bus();

  gpio_bus_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .gpio_out  (gpio_out),
    .gpio_in   (gpio_in),
    .irq       (irq),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // Drives one request with resp_ready high; latency counted in edges after the accept edge.
  task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_hit, input logic [31:0] exp_rdata, input int exp_lat,
                          input string tag, output logic [31:0] out_after_e1);
    int n;
    @(negedge clk);
    check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    out_after_e1 = '0;
    while (!bus.resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) out_after_e1 = gpio_out;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_hit"}, {31'd0, bus.resp_hit}, {31'd0, exp_hit});
    check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    @(posedge clk); #1;
    check({tag, "_done"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    gpio_in = '0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    wait_cycles(3);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_hit", {31'd0, bus.resp_hit}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_gpio_out", gpio_out, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);

    transact(1'b1, 32'h0000ABCD, 32'hDEADBEEF, 1'b1, 32'h0, 2, "st_out", out_c2);
    check("st_out_gpio_c2", out_c2, 32'hDEADBEEF);
    transact(1'b0, 32'h0000ABCD, 32'h0, 1'b1, 32'hDEADBEEF, 2, "ld_out", out_c2);

    @(negedge clk);
    gpio_in = 32'h0000A5A5;
    wait_cycles(3);
    transact(1'b0, 32'h0000ABD0, 32'h0, 1'b1, 32'h0000A5A5, 2, "ld_in", out_c2);
    transact(1'b1, 32'h0000ABD0, 32'h55555555, 1'b0, 32'h0, 1, "st_in", out_c2);
    check("st_in_gpio_kept", gpio_out, 32'hDEADBEEF);
    transact(1'b0, 32'h00001000, 32'h0, 1'b0, 32'h0, 1, "ld_miss", out_c2);
    transact(1'b1, 32'h0000ABCE, 32'h11111111, 1'b0, 32'h0, 1, "st_near", out_c2);
    check("st_near_gpio_kept", gpio_out, 32'hDEADBEEF);
`ifdef GPIO_IRQ_EN
    transact(1'b0, 32'h0000ABD4, 32'h0, 1'b1, 32'h0000A5A5, 2, "ld_irq_a5", out_c2);
`else
    transact(1'b0, 32'h0000ABD4, 32'h0, 1'b0, 32'h0, 1, "ld_irq_miss", out_c2);
`endif

    // Response stall: extra requests (stores of 0 to the output register) must be ignored.
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0000ABCD;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_cycles(2);
    check("stall_valid_start", {31'd0, bus.resp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h0000ABCD;
      bus.req_wdata = 32'h0;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("stall_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      check("stall_rdata", bus.resp_rdata, 32'hDEADBEEF);
      check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    wait_cycles(1);
    check("stall_release", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
    wait_cycles(3);
    check("stall_no_phantom", {29'd0, state_dbg}, 32'd0);
    check("stall_gpio_kept", gpio_out, 32'hDEADBEEF);

    // Reset while in WRITE aborts the store.
    @(negedge clk);
    gpio_in = '0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h0000ABCD;
    bus.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_state_write", {29'd0, state_dbg}, 32'd2);
    check("abort_gpio_before", gpio_out, 32'h12345678);
    rst_n = 1'b0;
    #1;
    check("abort_gpio_zero", gpio_out, 32'd0);
    check("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(3);
    check("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort_no_resp", {31'd0, bus.resp_valid}, 32'd0);

    // gpio_in[3] rising edge.
    @(negedge clk);
    gpio_in = 32'h00000008;
    wait_cycles(4);
`ifdef GPIO_IRQ_EN
    check("irq_set", {31'd0, irq}, 32'd1);
    transact(1'b0, 32'h0000ABD4, 32'h0, 1'b1, 32'h00000008, 2, "ld_irq", out_c2);
    wait_cycles(1);
    check("irq_cleared", {31'd0, irq}, 32'd0);
`else
    check("irq_stays_low", {31'd0, irq}, 32'd0);
    transact(1'b0, 32'h0000ABD4, 32'h0, 1'b0, 32'h0, 1, "ld_irq_off", out_c2);
    check("irq_still_low", {31'd0, irq}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gpio_bus_ctrl.md
# gpio_bus_ctrl

Memory-mapped GPIO controller on the processor data bus. It accepts single load/store requests over a valid/ready handshake and decodes the address against fixed GPIO register addresses. Matching stores update the 32-bit output register and matching loads return output or synchronized input data. A response is issued for every request, including misses.

## Interface
Parameters:
- GPIO_OUT_ADDR, 32'h0000ABCD, address of the R/W output register
- GPIO_IN_ADDR, 32'h0000ABD0, address of the read-only input register
- GPIO_IRQ_ADDR, 32'h0000ABD4, address of the interrupt-pending register (used only with GPIO_IRQ_EN)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts the response
- resp_hit  out  1  address decoded to a valid register for this access type
- resp_rdata  out  32  load data; 0 on stores and misses
- gpio_out  out  32  output pins
- gpio_in  in  32  asynchronous input pins
- irq  out  1  interrupt request (constant 0 without GPIO_IRQ_EN)

## Operation
- FSM states: IDLE, DECODE, WRITE, READ, RESP.
- IDLE
  - req_ready=1.
  - On req_valid, capture we/addr/wdata and go to DECODE.
- DECODE
  - Register the equality compares of the captured address against each parameter address.
  - Store to GPIO_OUT_ADDR → WRITE.
  - Load from any valid address → READ.
  - Anything else → RESP with hit=0.
  - Stores to GPIO_IN_ADDR and GPIO_IRQ_ADDR are misses; no state changes.
- WRITE: gpio_out ← wdata; hit=1; → RESP.
- READ: hit=1; → RESP. rdata is selected as follows:
  - OUT address: gpio_out
  - IN address: gpio_in_sync
  - IRQ address: irq_pending
- RESP
  - resp_valid=1; resp_hit and resp_rdata held stable.
  - On resp_ready, go to IDLE.
- req_ready=0 in every state except IDLE. Only one transaction is in flight at a time.
- gpio_in passes through a 2-flop synchronizer (gpio_in_sync) and is never sampled raw.

## Timing
- Reset values:
  - state=IDLE, req_ready=1, resp_valid=0, resp_hit=0, resp_rdata=0
  - gpio_out=0, synchronizer flops=0, irq_pending=0, irq=0
- Latency, counted from the accept edge (cycle 0):
  - hit: resp_valid rises after the edge at cycle 2 (visible in cycle 3)
  - miss: visible in cycle 2
- gpio_out changes on the WRITE-state edge, one cycle before resp_valid.
- With resp_ready held high, resp_valid lasts 1 cycle. IDLE and req_ready=1 follow on the next cycle, so the back-to-back request rate is 1 per 4 cycles for hits.
- gpio_in → gpio_in_sync latency is 2 cycles. A READ returns the value synchronized at the READ edge.
- Asserting rst_n low mid-transaction aborts it immediately:
  - no response is issued
  - gpio_out returns to 0
- Deasserting req_valid while in a non-IDLE state has no effect; the captured request completes.

## Configuration
- GPIO_IRQ_EN defined:
  - A 32-bit irq_pending register is added. Each bit sets on a rising edge of the corresponding gpio_in_sync bit (a third flop holds the previous value).
  - irq = |irq_pending, registered.
  - A load hit on GPIO_IRQ_ADDR returns irq_pending and clears it on the READ edge. An edge arriving on that same edge stays set.
- GPIO_IRQ_EN undefined:
  - No pending logic; irq tied to 0.
  - GPIO_IRQ_ADDR decodes as a miss (hit=0, rdata=0).

## Test plan
- Reset, then store 32'hDEADBEEF to 32'hABCD with resp_ready=1 → gpio_out=32'hDEADBEEF at cycle 2; resp_valid=1, resp_hit=1, resp_rdata=0 in cycle 3. Follow with a load from 32'hABCD → rdata=32'hDEADBEEF.
- Drive gpio_in=32'h0000A5A5, wait 3 cycles, load 32'hABD0 → resp_hit=1, rdata=32'h0000A5A5. Store to 32'hABD0 → resp_hit=0, gpio_out unchanged.
- Load from 32'h00001000 → resp_valid in cycle 2, resp_hit=0, rdata=0.
- Hold resp_ready=0 for 5 cycles during RESP → resp_valid and rdata stay stable and req_ready stays 0. New req_valid pulses are ignored until resp_ready=1.
- Assert rst_n=0 in WRITE state after gpio_out=32'h12345678 → gpio_out=0 and resp_valid=0 asynchronously. After release, req_ready=1.
- (GPIO_IRQ_EN) Toggle gpio_in[3] 0→1 → irq=1 within 4 cycles. Load 32'hABD4 → rdata=32'h00000008 and irq=0 afterwards. Repeat the test without the macro → irq stays 0 and the load misses.
